// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road traffic-light controller driven by a periodic tick.
// Green holds while the road's sensor reports traffic and the minimum green has elapsed.
// The phase order is green, yellow, all-red, then the other road's green.
// Dwell times are counted in ticks, not clock cycles.
// Optional feature macro TL_MAX_GREEN_EN adds a forced green timeout (MAX_GREEN_TICKS).
// When the macro is defined, the controller also drives a max_green_hit pulse output.
module traffic_light_ctrl #(
    parameter int MIN_GREEN_TICKS = 4,
    parameter int YELLOW_TICKS    = 3,
    parameter int ALL_RED_TICKS   = 1,
    parameter int MAX_GREEN_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       green_start
`ifdef TL_MAX_GREEN_EN
    ,
    output logic       max_green_hit
`endif
);

    // Counter width covers the largest dwell parameter.
    localparam int P_01  = (MIN_GREEN_TICKS > YELLOW_TICKS) ? MIN_GREEN_TICKS : YELLOW_TICKS;
    localparam int P_23  = (ALL_RED_TICKS > MAX_GREEN_TICKS) ? ALL_RED_TICKS : MAX_GREEN_TICKS;
    localparam int P_MAX = (P_01 > P_23) ? P_01 : P_23;
    localparam int CW    = $clog2(P_MAX + 1);

    localparam logic [1:0] L_GRN = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_RED = 2'b10;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        A_RR  = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        B_RR  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_la;
    logic [1:0]      r_lb;
    logic            r_green_start;
`ifdef TL_MAX_GREEN_EN
    logic            r_max_hit;
    logic            w_max_ok;
`endif

    state_t          w_state_next;
    logic [CW:0]     w_n;
    logic            w_min_ok;
    logic            w_yel_ok;
    logic            w_rr_ok;
    logic            w_changed;
    logic            w_timeout;
    logic            w_green_entry;
    logic [1:0]      w_la_next;
    logic [1:0]      w_lb_next;

    // n is the tick count including the current tick; one bit wider so it never wraps.
    assign w_n      = {1'b0, r_cnt} + (CW + 1)'(1);
    assign w_min_ok = (w_n >= (CW + 1)'(MIN_GREEN_TICKS));
    assign w_yel_ok = (w_n >= (CW + 1)'(YELLOW_TICKS));
    assign w_rr_ok  = (w_n >= (CW + 1)'(ALL_RED_TICKS));
`ifdef TL_MAX_GREEN_EN
    assign w_max_ok = (w_n >= (CW + 1)'(MAX_GREEN_TICKS));
`endif

    // Next-state decision; phases advance only on tick, illegal codes recover at once.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            A_GRN: begin
                if (tick) begin
                    if (w_min_ok && !ta) begin
                        w_state_next = A_YEL;
                    end
`ifdef TL_MAX_GREEN_EN
                    else if (w_max_ok) begin
                        w_state_next = A_YEL;
                        w_timeout    = 1'b1;
                    end
`endif
                end
            end
            A_YEL:   if (tick && w_yel_ok) w_state_next = A_RR;
            A_RR:    if (tick && w_rr_ok)  w_state_next = B_GRN;
            B_GRN: begin
                if (tick) begin
                    if (w_min_ok && !tb) begin
                        w_state_next = B_YEL;
                    end
`ifdef TL_MAX_GREEN_EN
                    else if (w_max_ok) begin
                        w_state_next = B_YEL;
                        w_timeout    = 1'b1;
                    end
`endif
                end
            end
            B_YEL:   if (tick && w_yel_ok) w_state_next = B_RR;
            B_RR:    if (tick && w_rr_ok)  w_state_next = A_GRN;
            default: w_state_next = A_GRN;
        endcase
    end

    assign w_changed     = (w_state_next != r_state);
    assign w_green_entry = w_changed
                         && ((w_state_next == A_GRN) || (w_state_next == B_GRN))
                         && ((r_state == A_RR) || (r_state == B_RR));

    // Lamp decode of the upcoming state so the lamp registers track the state register.
    always_comb begin
        w_la_next = L_RED;
        w_lb_next = L_RED;
        case (w_state_next)
            A_GRN:   w_la_next = L_GRN;
            A_YEL:   w_la_next = L_YEL;
            B_GRN:   w_lb_next = L_GRN;
            B_YEL:   w_lb_next = L_YEL;
            default: ;
        endcase
    end

    // State, dwell counter and registered lamp/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= A_GRN;
            r_cnt         <= '0;
            r_la          <= L_GRN;
            r_lb          <= L_RED;
            r_green_start <= 1'b0;
`ifdef TL_MAX_GREEN_EN
            r_max_hit     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_la          <= w_la_next;
            r_lb          <= w_lb_next;
            r_green_start <= w_green_entry;
`ifdef TL_MAX_GREEN_EN
            r_max_hit     <= w_timeout;
`endif
            if (w_changed) begin
                r_cnt <= '0;
            end else if (tick && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign la          = r_la;
    assign lb          = r_lb;
    assign green_start = r_green_start;
`ifdef TL_MAX_GREEN_EN
    assign max_green_hit = r_max_hit;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed testbench for traffic_light_ctrl (default parameters).
// Expected lamp sequences are hand-written state tables.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       ta;
    logic       tb;
    logic [1:0] la;
    logic [1:0] lb;
    logic       green_start;
`ifdef TL_MAX_GREEN_EN
    logic       max_green_hit;
`endif

    int checks = 0;
    int errors = 0;

    localparam int AG = 0, AY = 1, AR = 2, BG = 3, BY = 4, BR = 5;

    // State after each tick, tick every third cycle, sensors idle, starting fresh in A green.
    int t2_tbl [16] = '{AG, AG, AG, AY, AY, AY, AR, BG, BG, BG, BG, BY, BY, BY, BR, AG};
    // State after each cycle with tick held high, starting in A green past min green.
    int t5_tbl [26] = '{AY, AY, AY, AR, BG, BG, BG, BG, BY, BY, BY, BR, AG,
                        AG, AG, AG, AY, AY, AY, AR, BG, BG, BG, BG, BY, BY};
    // State after each tick with both sensors held high and the timeout enabled.
    int t6_tbl [27] = '{AG, AG, AG, AG, AG, AG, AG, AY, AY, AY, AR,
                        BG, BG, BG, BG, BG, BG, BG, BG, BY, BY, BY, BR,
                        AG, AG, AG, AG};

    traffic_light_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .ta          (ta),
        .tb          (tb),
        .la          (la),
        .lb          (lb),
        .green_start (green_start)
`ifdef TL_MAX_GREEN_EN
        ,
        .max_green_hit (max_green_hit)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] la_of(input int s);
        if (s == AG) return 2'b00;
        if (s == AY) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] lb_of(input int s);
        if (s == BG) return 2'b00;
        if (s == BY) return 2'b01;
        return 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int s, input logic gs);
        chk({tag, " la"}, la, la_of(s));
        chk({tag, " lb"}, lb, lb_of(s));
        chk({tag, " green_start"}, {1'b0, green_start}, {1'b0, gs});
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        ta    = 1'b0;
        tb    = 1'b0;

        // Power-on reset.
        cyc(1'b0);
        cyc(1'b0);
        chk_state("por", AG, 1'b0);
        reset = 1'b0;

        // Basic cycle, tick every third cycle.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1);
            chk_state($sformatf("basic tick%0d", i + 1), t2_tbl[i], (i == 7) || (i == 15));
            $display("basic tick %0d: la=%b lb=%b gs=%b", i + 1, la, lb, green_start);
            cyc(1'b0);
            chk($sformatf("basic tick%0d gs width", i + 1), {1'b0, green_start}, 2'b00);
            cyc(1'b0);
        end

`ifndef TL_MAX_GREEN_EN
        // Sensor hold on road A.
        ta = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            chk($sformatf("hold tick%0d la", i + 1), la, 2'b00);
            cyc(1'b0);
            cyc(1'b0);
        end
        ta = 1'b0;
        cyc(1'b1);
        chk_state("hold release", AY, 1'b0);
        $display("hold release: la=%b lb=%b", la, lb);
        cyc(1'b0);
        cyc(1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
        end
        chk_state("hold back to A", AG, 1'b0);

        // Sensor drop between ticks is ignored.
        ta = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            chk_state($sformatf("glitch pre tick%0d", i + 1), AG, 1'b0);
            cyc(1'b0);
            cyc(1'b0);
        end
        ta = 1'b0;
        cyc(1'b0);
        ta = 1'b1;
        cyc(1'b0);
        chk_state("glitch between", AG, 1'b0);
        cyc(1'b1);
        chk_state("glitch tick", AG, 1'b0);
        $display("glitch tick: la=%b lb=%b", la, lb);
        cyc(1'b0);
        cyc(1'b0);
`else
        // Forced green timeout with constant traffic on both roads.
        ta = 1'b1;
        tb = 1'b1;
        for (int i = 0; i < 27; i++) begin
            cyc(1'b1);
            chk_state($sformatf("maxg tick%0d", i + 1), t6_tbl[i], (i == 11) || (i == 23));
            chk($sformatf("maxg tick%0d hit", i + 1), {1'b0, max_green_hit},
                {1'b0, (i == 7) || (i == 19)});
            $display("maxg tick %0d: la=%b lb=%b hit=%b", i + 1, la, lb, max_green_hit);
        end
        tick = 1'b0;
`endif

        // Tick held high, sensors idle.
        ta = 1'b0;
        tb = 1'b0;
        for (int i = 0; i < 26; i++) begin
            cyc(1'b1);
            chk_state($sformatf("cont c%0d", i + 1), t5_tbl[i], (i == 4) || (i == 12) || (i == 20));
            $display("cont cycle %0d: la=%b lb=%b gs=%b", i + 1, la, lb, green_start);
        end

        // Asynchronous reset in the middle of B yellow, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk_state("async reset", AG, 1'b0);
        $display("async reset: la=%b lb=%b", la, lb);
        cyc(1'b1);
        cyc(1'b1);
        chk_state("reset held", AG, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0);
            chk_state($sformatf("post reset c%0d", i + 1), AG, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            chk_state($sformatf("post reset tick%0d", i + 1), (i == 3) ? AY : AG, 1'b0);
            $display("post reset tick %0d: la=%b lb=%b", i + 1, la, lb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-road traffic-light controller that advances only on a periodic one-cycle enable pulse (tick), such as the output of the team's divide-by-N FSM.
- Holds green on road A while sensor traffic is present.
- Sequences green -> yellow -> all-red -> other road's green, with dwell times counted in ticks.
- Sits directly downstream of the tick divider; drives the lamp drivers.

Parameters:
MIN_GREEN_TICKS, 4, minimum ticks a green phase lasts (>=1)
YELLOW_TICKS, 3, ticks a yellow phase lasts (>=1)
ALL_RED_TICKS, 1, ticks both roads show red between phases (>=1)
MAX_GREEN_TICKS, 8, forced green timeout; used only with TL_MAX_GREEN_EN (> MIN_GREEN_TICKS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle advance enable from the upstream divider; may be held high (every cycle counts as a tick)
ta  input  1  traffic present on road A (sampled only on tick cycles)
tb  input  1  traffic present on road B (sampled only on tick cycles)
la  output  2  road A lamp: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED
lb  output  2  road B lamp, same encoding
green_start  output  1  one-cycle pulse, registered, high in the first cycle of any green phase

Behaviour:
- One clock; reset is asynchronous and active-high, on ports clk and reset.
- Reset (asserted at any time, including mid-phase):
  - state = A_GRN, dwell counter cnt = 0, green_start = 0.
  - la = GREEN, lb = RED immediately (asynchronously).
- States and lamps (Moore, decoded from the state register only):
  - A_GRN: la=GREEN, lb=RED
  - A_YEL: la=YELLOW, lb=RED
  - A_RR: la=RED, lb=RED
  - B_GRN: la=RED, lb=GREEN
  - B_YEL: la=RED, lb=YELLOW
  - B_RR: la=RED, lb=RED
- Encoding 2'b11 never appears on la/lb.
- Dwell counter cnt:
  - Width $clog2(max parameter + 1).
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 on each tick cycle, saturating at all-ones.
- State only changes on cycles with tick=1. On a tick cycle, with n = cnt + 1:
  - A_GRN -> A_YEL if n >= MIN_GREEN_TICKS and ta==0.
  - A_YEL -> A_RR if n >= YELLOW_TICKS.
  - A_RR -> B_GRN if n >= ALL_RED_TICKS.
  - B_GRN -> B_YEL if n >= MIN_GREEN_TICKS and tb==0.
  - B_YEL -> B_RR if n >= YELLOW_TICKS.
  - B_RR -> A_GRN if n >= ALL_RED_TICKS.
- Latency and sampling:
  - A transition decided on tick cycle T appears on la/lb in cycle T+1.
  - ta/tb changes between ticks have no effect; only the value at a tick is used.
- green_start:
  - Registered; asserted in cycle T+1 when entering A_GRN or B_GRN from x_RR.
  - Not asserted on release from reset.
- Illegal state encodings: next state = A_GRN, cnt cleared.
- Continuous sensor presence: green holds indefinitely (no timeout) unless TL_MAX_GREEN_EN is defined.

Optional Feature:
Macro TL_MAX_GREEN_EN.
- Defined: on a tick cycle in A_GRN/B_GRN, if n >= MAX_GREEN_TICKS, the controller moves to x_YEL regardless of ta/tb.
  - This guarantees road B is served even with constant road-A traffic, and vice versa.
  - Adds output max_green_hit (1 bit, reset 0), a one-cycle registered pulse whenever a green exits due to the timeout rather than a sensor.
- Not defined: MAX_GREEN_TICKS is unused, max_green_hit does not exist, and green exit depends only on MIN_GREEN_TICKS and the sensor.

Test Plan:
1. Reset: assert reset mid-B_YEL with clk running -> la=00, lb=10 immediately; after release with tick=0 for 20 cycles, lamps unchanged and green_start=0.
2. Basic cycle: tick every 3rd cycle, ta=tb=0 -> A green for 4 ticks, yellow 3, all-red 1, then B green with green_start high for exactly one cycle; full A+B period = 16 ticks = 48 cycles.
3. Sensor hold: ta=1 throughout, 20 ticks -> la stays 00 (macro off); drop ta before tick 21 -> la=01 in the cycle after tick 21.
4. Between-tick sensor glitch: ta pulses 0 for one non-tick cycle after min green -> no transition.
5. tick held high continuously, ta=tb=0 -> transitions every 4/3/1 cycles; cnt clears correctly on back-to-back state changes.
6. With TL_MAX_GREEN_EN: ta=1, tb=1 constantly -> A green exits at tick 8, max_green_hit pulses once, and B green likewise exits after 8 ticks.
